// File: rtl/icache_fill_ctrl_pkg.sv
// Shared cache definitions: fill FSM encoding, address field layout and block helpers.
package icache_fill_ctrl_pkg;

  localparam int unsigned ADDR_W          = 16;
  localparam int unsigned WORD_W          = 16;
  localparam int unsigned WORDS_PER_BLOCK = 8;
  localparam int unsigned CNT_W           = 4;
  localparam int unsigned OFFSET_W        = 4;
  localparam int unsigned INDEX_W         = 6;
  localparam int unsigned TAG_W           = 6;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    FILL = 2'b01,
    TAG  = 2'b10
  } fill_state_e;

  typedef struct packed {
    logic [TAG_W-1:0]    tag;
    logic [INDEX_W-1:0]  index;
    logic [OFFSET_W-1:0] offset;
  } cache_addr_t;

  // Align a byte address down to the start of its cache block.
  function automatic logic [ADDR_W-1:0] block_base(input logic [ADDR_W-1:0] addr);
    cache_addr_t a;
    a        = cache_addr_t'(addr);
    a.offset = '0;
    return ADDR_W'(a);
  endfunction

  // Byte address of word number cnt within the block starting at base.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [CNT_W-1:0]  cnt);
    return base + ADDR_W'({cnt, 1'b0});
  endfunction

endpackage

// File: rtl/icache_fill_ctrl_fill_word_counter.sv
// Saturating 0..WORDS_PER_BLOCK word counter with synchronous clear; done_c flags a full block.
module icache_fill_ctrl_fill_word_counter
  import icache_fill_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             done_c
);

  assign done_c = (count == CNT_W'(WORDS_PER_BLOCK));

  // Clear wins over increment; the count holds once the block is complete.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && !done_c) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/icache_fill_ctrl.sv
// I-cache miss fill controller: fetches an 8-word block from pipelined memory and streams it into the cache.
module icache_fill_ctrl
  import icache_fill_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic              mem_grant,
  input  logic              memory_data_valid,
  input  logic [WORD_W-1:0] memory_data_out,
  output logic              memory_enable,
  output logic [ADDR_W-1:0] memory_address,
  output logic              fsm_busy,
  output logic              write_data_array,
  output logic [ADDR_W-1:0] fill_address,
  output logic [WORD_W-1:0] fill_data,
  output logic              write_tag_array
);

  fill_state_e       state, state_next;
  logic [ADDR_W-1:0] base, base_next;
  logic              cnt_clear;
  logic              issue_req, issue_inc, recv_inc;
  logic [CNT_W-1:0]  issue_cnt, recv_cnt;
  logic              issue_done_c, recv_done_c;

  icache_fill_ctrl_fill_word_counter u_issue_cnt (
    .clk    (clk),
    .rst    (rst),
    .clear  (cnt_clear),
    .inc    (issue_inc),
    .count  (issue_cnt),
    .done_c (issue_done_c)
  );

  icache_fill_ctrl_fill_word_counter u_recv_cnt (
    .clk    (clk),
    .rst    (rst),
    .clear  (cnt_clear),
    .inc    (recv_inc),
    .count  (recv_cnt),
    .done_c (recv_done_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      base  <= '0;
    end else begin
      state <= state_next;
      base  <= base_next;
    end
  end

  // Next state, counter controls and the combinational cache/memory strobes.
  always_comb begin
    state_next       = state;
    base_next        = base;
    cnt_clear        = 1'b0;
    issue_req        = 1'b0;
    issue_inc        = 1'b0;
    recv_inc         = 1'b0;
    memory_enable    = 1'b0;
    memory_address   = '0;
    fsm_busy         = 1'b0;
    write_data_array = 1'b0;
    fill_address     = '0;
    fill_data        = '0;
    write_tag_array  = 1'b0;

    case (state)
      IDLE: begin
        if (miss_detected) begin
          base_next  = block_base(miss_address);
          cnt_clear  = 1'b1;
          state_next = FILL;
        end
      end

      FILL: begin
        fsm_busy      = 1'b1;
        fill_address  = base;
        issue_req     = !issue_done_c;
        memory_enable = issue_req;
        issue_inc     = issue_req && mem_grant;
        // Address is only presented while requesting, so it never leaves the block.
        if (issue_req) begin
          memory_address = word_addr(base, issue_cnt);
        end
        if (memory_data_valid && !recv_done_c) begin
          write_data_array = 1'b1;
          fill_address     = word_addr(base, recv_cnt);
          fill_data        = memory_data_out;
          recv_inc         = 1'b1;
          if (recv_cnt == CNT_W'(WORDS_PER_BLOCK - 1)) begin
            state_next = TAG;
          end
        end
      end

      TAG: begin
        fsm_busy        = 1'b1;
        write_tag_array = 1'b1;
        fill_address    = base;
        state_next      = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
